inv_subbytes_seq: RTL and testbench

- Iterative AES InvSubBytes unit for the decryption datapath. It applies the FIPS-197 inverse S-box to every byte of a 128-bit state.
- It processes BYTES_PER_CYCLE bytes per clock and uses a valid/ready handshake on both the input and output side.
- It is the decrypt-direction counterpart of the combinational Subbytes block. It feeds the inverse-round sequencer, which is area-constrained, so only BYTES_PER_CYCLE inverse S-box instances exist.

---
 rtl/inv_subbytes_seq.sv | 104 ++++++++++
 tb/tb_inv_subbytes_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per
// clock using the FIPS-197 inverse S-box, with valid/ready handshakes on both sides.
module inv_subbytes_seq #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] msgout,
  output logic         busy
);

  localparam int unsigned N       = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CHUNK_W = 8 * BYTES_PER_CYCLE;

  generate
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
      $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [127:0]         work;
  logic [CHUNK_W-1:0]   chunk_in;
  logic [CHUNK_W-1:0]   chunk_out;

  // Chunk 0 sits in the most-significant bits of the work register.
  always_comb begin
    chunk_in = '0;
    for (int unsigned c = 0; c < N; c++) begin
      if (count == CW'(c)) chunk_in = work[(N-1-c)*CHUNK_W +: CHUNK_W];
    end
  end

  always_comb begin
    chunk_out = '0;
    for (int unsigned l = 0; l < BYTES_PER_CYCLE; l++) begin
      chunk_out[l*8 +: 8] = INV_SBOX[chunk_in[l*8 +: 8]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      work  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= msg;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          for (int unsigned c = 0; c < N; c++) begin
            if (count == CW'(c)) work[(N-1-c)*CHUNK_W +: CHUNK_W] <= chunk_out;
          end
          count <= count + CW'(1);
          if (count == CW'(N-1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign msgout    = work;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Scoreboard bench for inv_subbytes_seq; the reference inverse S-box is derived from
// GF(2^8) inversion plus the AES affine map, then inverted as a lookup table.
module tb_inv_subbytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] msg, msgout;

  logic         sw_valid, sw_ready;
  logic [127:0] sw_msg;
  logic         r1, v1, b1, r16, v16, b16;
  logic [127:0] o1, o16;

  always #5 clk = ~clk;

  inv_subbytes_seq #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .msg(msg),
    .out_valid(out_valid), .out_ready(out_ready), .msgout(msgout), .busy(busy)
  );

  inv_subbytes_seq #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r1), .msg(sw_msg),
    .out_valid(v1), .out_ready(sw_ready), .msgout(o1), .busy(b1)
  );

  inv_subbytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r16), .msg(sw_msg),
    .out_valid(v16), .out_ready(sw_ready), .msgout(o16), .busy(b16)
  );

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  bit         rand_ready = 0;
  logic       prev_ov = 1'b0;
  logic [7:0] inv_tab [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_table();
    logic [7:0] ginv [256];
    logic [7:0] s, y;
    ginv[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      for (int b = 1; b < 256; b++) begin
        if (gf_mul(8'(a), 8'(b)) == 8'h01) ginv[a] = 8'(b);
      end
    end
    for (int x = 0; x < 256; x++) begin
      s = ginv[x];
      y = s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
      inv_tab[y] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_model(input logic [127:0] m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[m[127-8*i -: 8]];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every DONE cycle so a held result must also stay stable.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected no output", msgout);
      end else begin
        check("msgout", msgout, q[0].data);
        check("in_ready_in_done", {127'b0, in_ready}, 128'd0);
        if (!prev_ov) check_int("latency", cyc - q[0].acc, 4);
      end
    end
    prev_ov = out_valid;
  end

  always @(posedge clk) begin
    if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
  end

  task automatic send(input logic [127:0] data, input logic [127:0] exp);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    msg      = data;
    n        = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1");
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      e.data = exp;
      e.acc  = cyc;
      q.push_back(e);
      in_valid = 1'b0;
      msg      = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_out", {127'b0, out_valid}, 128'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready && q.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {127'b0, in_ready}, 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int           acc, lat1, lat16;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; msg = '0;
    sw_valid = 1'b0; sw_ready = 1'b1; sw_msg = '0;
    build_table();
    #1;
    check("reset_in_ready", {127'b0, in_ready}, 128'd1);
    check("reset_out_valid", {127'b0, out_valid}, 128'd0);
    check("reset_busy", {127'b0, busy}, 128'd0);
    check("reset_msgout", msgout, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 vector with the consumer always ready.
    out_ready = 1'b1;
    send(128'h63cab7040953d051cd60e0e7ba70e18c, 128'h00102030405060708090a0b0c0d0e0f0);
    wait_out();
    @(negedge clk);
    check("done_one_cycle", {127'b0, out_valid}, 128'd0);
    check("idle_after_done", {127'b0, in_ready}, 128'd1);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(128'ha761ca9b97be8b45d8ad1a611fc97369, 128'h89d810e8855ace682d1843d8cb128fe4);
    wait_out();
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", {127'b0, in_ready}, 128'd0);
      check("bp_out_valid", {127'b0, out_valid}, 128'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {127'b0, out_valid}, 128'd0);
    check("bp_release_ready", {127'b0, in_ready}, 128'd1);

    // Table boundaries.
    send('0, {16{8'h52}});
    wait_idle();
    send('1, {16{8'h7d}});
    wait_idle();
    send(128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
    wait_idle();

    // in_valid while BUSY must be ignored.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, ref_model(d));
    check("busy_flag", {127'b0, busy}, 128'd1);
    in_valid = 1'b1;
    msg      = '1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);

    // Asynchronous reset at BUSY counter==2.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, ref_model(d));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {127'b0, in_ready}, 128'd1);
    check("midrst_out_valid", {127'b0, out_valid}, 128'd0);
    check("midrst_busy", {127'b0, busy}, 128'd0);
    check("midrst_msgout", msgout, 128'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, ref_model(d));
    wait_idle();

    // Random blocks with random consumer backpressure.
    rand_ready = 1'b1;
    fork
      while (rand_ready) begin
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, ref_model(d));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle();

    // Parameter sweep: BYTES_PER_CYCLE=1 and 16 on the FIPS vector.
    lat1 = -1; lat16 = -1;
    sw_msg   = 128'h63cab7040953d051cd60e0e7ba70e18c;
    sw_ready = 1'b1;
    sw_valid = 1'b1;
    @(negedge clk);
    acc      = cyc;
    sw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (v1 && lat1 < 0) begin
        lat1 = cyc - acc;
        check("sweep1_msgout", o1, 128'h00102030405060708090a0b0c0d0e0f0);
      end
      if (v16 && lat16 < 0) begin
        lat16 = cyc - acc;
        check("sweep16_msgout", o16, 128'h00102030405060708090a0b0c0d0e0f0);
      end
      @(negedge clk);
    end
    check_int("sweep1_latency", lat1, 16);
    check_int("sweep16_latency", lat16, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
